wavepool_inst_queue: RTL and testbench
======================================

# wavepool_inst_queue

Per-wavefront instruction queue bank for the wavepool, directly upstream of the scoreboard feeder. Fetch writes returned instructions into one of NUM_WF circular queues; the feeder's selection (feed_valid/feed_wfid) pops the head of the chosen queue, and the block returns the popped instruction one cycle later. It produces the q_empty and q_reset vectors that the feeder consumes, plus a per-wavefront space indication for fetch.

## Interface
- NUM_WF, 40, number of wavefront slots/queues
- WFID_W, 6, wavefront id width
- DEPTH, 4, entries per queue (power of 2, ≥2)
- PTR_W, 2, log2(DEPTH)
- DATA_W, 32, instruction word width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_valid  in  1  fetch write strobe
- wr_wfid  in  WFID_W  target queue for write
- wr_data  in  DATA_W  instruction word
- feed_valid  in  1  feeder pop request
- feed_wfid  in  WFID_W  queue to pop
- flush_valid  in  1  flush request (branch/halt/dealloc)
- flush_wfid  in  WFID_W  queue to flush
- q_empty  out  NUM_WF  bit i = queue i holds 0 entries
- q_vacant  out  NUM_WF  bit i = queue i has ≥2 free entries
- q_reset  out  NUM_WF  one-cycle pulse, bit i = queue i was flushed last edge
- rd_valid  out  1  popped instruction valid
- rd_wfid  out  WFID_W  wfid of popped instruction
- rd_data  out  DATA_W  popped instruction
- wr_overflow  out  1  one-cycle pulse: write dropped (queue full)
- rd_underflow  out  1  one-cycle pulse: pop of empty queue

## Operation
- Per queue: head ptr, tail ptr (PTR_W, wrap modulo DEPTH), count (PTR_W+1 bits, 0..DEPTH); storage NUM_WF×DEPTH×DATA_W.
- Write: if wr_valid, wr_wfid < NUM_WF, count<DEPTH (pre-edge) and not flushed this cycle → store at tail, tail+1, count+1. If count==DEPTH → dropped, wr_overflow=1 next cycle.
- Pop: if feed_valid, feed_wfid < NUM_WF, count>0 (pre-edge), not flushed this cycle → rd_data<=entry[head], rd_wfid<=feed_wfid, rd_valid<=1, head+1, count−1. If count==0 → rd_valid<=0, rd_underflow=1 next cycle.
- No write-to-read bypass: write+pop same empty queue same cycle → write stored, pop underflows.
- Write+pop same non-full queue → both occur, count unchanged. Write+pop same full queue → pop occurs, write dropped (full is judged on pre-edge count), wr_overflow pulses.
- Flush: flush_valid with flush_wfid < NUM_WF → head=tail=count=0 for that queue; q_reset[flush_wfid]=1 for the following cycle only. Flush beats same-cycle write and pop to the same wfid: write discarded without overflow, pop returns rd_valid=0 without underflow. Storage contents are not cleared.
- Out-of-range wfid (≥NUM_WF) on any port: request ignored, no pulses.
- q_empty[i]=(count_i==0); q_vacant[i]=(DEPTH−count_i ≥ 2); both decoded from registered state only (no input-to-output combinational path).

## Timing
- Reset (rst=0, async): all counts/ptrs 0; q_empty all 1; q_vacant all 1; q_reset 0; rd_valid 0; rd_wfid 0; rd_data 0; wr_overflow 0; rd_underflow 0. Storage not reset.
- Write at edge N → q_empty[i] falls after edge N; poppable from cycle N+1.
- Pop request cycle N → rd_valid/rd_data valid in cycle N+1 (1-cycle latency); rd_valid is a single-cycle pulse per pop; back-to-back pops supported every cycle.
- Flush at edge N → q_empty[i]=1, q_vacant[i]=1, q_reset[i]=1 in cycle N+1; q_reset clears at N+2 unless flushed again.
- rst asserted mid-operation: all state returns to reset values immediately; outputs in flight (rd_valid, pulses) are cancelled.
- q_vacant gives fetch one cycle of slack: a write issued on q_vacant=1 can never overflow even with an in-flight write.

## Test plan
- Reset then write 0xA0,0xA1 to wf 5 → q_empty[5]=0 after first write; pop wf 5 twice back-to-back → rd_data 0xA0 then 0xA1 in consecutive cycles, rd_wfid=5, q_empty[5]=1 after.
- Fill wf 39 with 4 writes → q_vacant[39]=0 after 3rd write; 5th write → wr_overflow pulse, later pops return the 4 original words in order.
- Pop empty wf 0 and same-cycle write+pop to empty wf 1 → two rd_underflow pulses, rd_valid=0; wf 1 then holds 1 entry.
- Wf 7 holds 3 entries; flush wf 7 with same-cycle write and pop to wf 7 → q_reset[7]=1 for exactly one cycle, q_empty[7]=1, rd_valid=0, no overflow/underflow.
- Pointer wrap: 10 cycles of interleaved write/pop on wf 20 with data 0..9 → outputs 0..9 in order, count never exceeds 2.
- Assert rst low with rd_valid pending and 3 queues non-empty → all outputs at reset values immediately, q_empty=all ones.

Source files
------------

// File: rtl/wavepool_inst_queue.sv
// Per-wavefront circular instruction queues between fetch and the scoreboard feeder.
// Flush dominates same-cycle write/pop to the same slot; popped words appear one cycle later.
module wavepool_inst_queue #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [WFID_W-1:0] wr_wfid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              feed_valid,
    input  logic [WFID_W-1:0] feed_wfid,
    input  logic              flush_valid,
    input  logic [WFID_W-1:0] flush_wfid,
    output logic [NUM_WF-1:0] q_empty,
    output logic [NUM_WF-1:0] q_vacant,
    output logic [NUM_WF-1:0] q_reset,
    output logic              rd_valid,
    output logic [WFID_W-1:0] rd_wfid,
    output logic [DATA_W-1:0] rd_data,
    output logic              wr_overflow,
    output logic              rd_underflow
);

    localparam logic [WFID_W:0] NUM_WF_C   = (WFID_W+1)'(NUM_WF);
    localparam logic [PTR_W:0]  DEPTH_C    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  VACANT_MAX = (PTR_W+1)'(DEPTH - 2);

    logic [DATA_W-1:0] mem_q [NUM_WF][DEPTH];
    logic [PTR_W-1:0]  head_q [NUM_WF];
    logic [PTR_W-1:0]  head_d [NUM_WF];
    logic [PTR_W-1:0]  tail_q [NUM_WF];
    logic [PTR_W-1:0]  tail_d [NUM_WF];
    logic [PTR_W:0]    cnt_q  [NUM_WF];
    logic [PTR_W:0]    cnt_d  [NUM_WF];

    logic [NUM_WF-1:0] q_reset_q, q_reset_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WFID_W-1:0] rd_wfid_q, rd_wfid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic wr_in, pop_in, flush_in;
    logic wr_fl, pop_fl;
    logic do_wr, do_pop;

    always_comb begin
        wr_in    = wr_valid    && ({1'b0, wr_wfid}    < NUM_WF_C);
        pop_in   = feed_valid  && ({1'b0, feed_wfid}  < NUM_WF_C);
        flush_in = flush_valid && ({1'b0, flush_wfid} < NUM_WF_C);
        wr_fl    = flush_in && (flush_wfid == wr_wfid);
        pop_fl   = flush_in && (flush_wfid == feed_wfid);

        // Full/empty are judged on the count before this edge, so no bypass exists.
        do_wr  = wr_in  && !wr_fl  && (cnt_q[wr_wfid] != DEPTH_C);
        do_pop = pop_in && !pop_fl && (cnt_q[feed_wfid] != '0);
        ovf_d  = wr_in  && !wr_fl  && (cnt_q[wr_wfid] == DEPTH_C);
        unf_d  = pop_in && !pop_fl && (cnt_q[feed_wfid] == '0);

        rd_valid_d = do_pop;
        rd_wfid_d  = rd_wfid_q;
        rd_data_d  = rd_data_q;
        if (do_pop) begin
            rd_wfid_d = feed_wfid;
            rd_data_d = mem_q[feed_wfid][head_q[feed_wfid]];
        end

        q_reset_d = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            head_d[i] = head_q[i];
            tail_d[i] = tail_q[i];
            cnt_d[i]  = cnt_q[i];
            if (flush_in && (flush_wfid == WFID_W'(i))) begin
                q_reset_d[i] = 1'b1;
                head_d[i]    = '0;
                tail_d[i]    = '0;
                cnt_d[i]     = '0;
            end else begin
                if (do_wr && (wr_wfid == WFID_W'(i)))
                    tail_d[i] = tail_q[i] + 1'b1;
                if (do_pop && (feed_wfid == WFID_W'(i)))
                    head_d[i] = head_q[i] + 1'b1;
                if ((do_wr && (wr_wfid == WFID_W'(i))) && !(do_pop && (feed_wfid == WFID_W'(i))))
                    cnt_d[i] = cnt_q[i] + 1'b1;
                else if (!(do_wr && (wr_wfid == WFID_W'(i))) && (do_pop && (feed_wfid == WFID_W'(i))))
                    cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_WF; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            q_reset_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_wfid_q  <= '0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            q_reset_q  <= q_reset_d;
            rd_valid_q <= rd_valid_d;
            rd_wfid_q  <= rd_wfid_d;
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Instruction storage is never cleared; pointers alone define queue contents.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem_q[wr_wfid][tail_q[wr_wfid]] <= wr_data;
    end

    always_comb begin
        for (int i = 0; i < NUM_WF; i++) begin
            q_empty[i]  = (cnt_q[i] == '0);
            q_vacant[i] = (cnt_q[i] <= VACANT_MAX);
        end
    end

    assign q_reset      = q_reset_q;
    assign rd_valid     = rd_valid_q;
    assign rd_wfid      = rd_wfid_q;
    assign rd_data      = rd_data_q;
    assign wr_overflow  = ovf_q;
    assign rd_underflow = unf_q;

endmodule

// File: tb/tb_wavepool_inst_queue.sv
// Bench for wavepool_inst_queue: directed scenarios plus random traffic against a queue-based model.
module tb_wavepool_inst_queue;
    localparam int NWF = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic [5:0]  wr_wfid = '0;
    logic [31:0] wr_data = '0;
    logic        feed_valid = 1'b0;
    logic [5:0]  feed_wfid = '0;
    logic        flush_valid = 1'b0;
    logic [5:0]  flush_wfid = '0;
    logic [39:0] q_empty, q_vacant, q_reset;
    logic        rd_valid;
    logic [5:0]  rd_wfid;
    logic [31:0] rd_data;
    logic        wr_overflow, rd_underflow;

    wavepool_inst_queue dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_wfid(wr_wfid), .wr_data(wr_data),
        .feed_valid(feed_valid), .feed_wfid(feed_wfid),
        .flush_valid(flush_valid), .flush_wfid(flush_wfid),
        .q_empty(q_empty), .q_vacant(q_vacant), .q_reset(q_reset),
        .rd_valid(rd_valid), .rd_wfid(rd_wfid), .rd_data(rd_data),
        .wr_overflow(wr_overflow), .rd_underflow(rd_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one SV queue of words per wavefront, plus expected registered outputs.
    logic [31:0] mdl [NWF][$];
    logic        e_rdv = 1'b0, e_ovf = 1'b0, e_unf = 1'b0;
    logic [31:0] e_rdata = '0;
    logic [5:0]  e_rwfid = '0;
    logic [39:0] e_qrst = '0;

    function automatic logic [39:0] m_empty();
        logic [39:0] r;
        for (int i = 0; i < NWF; i++) r[i] = (mdl[i].size() == 0);
        return r;
    endfunction

    function automatic logic [39:0] m_vacant();
        logic [39:0] r;
        for (int i = 0; i < NWF; i++) r[i] = (4 - mdl[i].size() >= 2);
        return r;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NWF; i++) mdl[i].delete();
        e_rdv = 0; e_ovf = 0; e_unf = 0; e_rdata = '0; e_rwfid = '0; e_qrst = '0;
    endfunction

    // Drives one cycle of requests, advances the model, and returns 1ns after the edge.
    task automatic step(input bit wv, input int ww, input logic [31:0] wd,
                        input bit fv, input int fw, input bit flv, input int flw);
        bit fl_ok, wr_go, pop_go;
        wr_valid = wv; wr_wfid = 6'(ww); wr_data = wd;
        feed_valid = fv; feed_wfid = 6'(fw);
        flush_valid = flv; flush_wfid = 6'(flw);
        e_rdv = 0; e_ovf = 0; e_unf = 0; e_qrst = '0;
        fl_ok = flv && (flw < NWF);
        wr_go = 0; pop_go = 0;
        if (wv && ww < NWF && !(fl_ok && flw == ww)) begin
            if (mdl[ww].size() == 4) e_ovf = 1; else wr_go = 1;
        end
        if (fv && fw < NWF && !(fl_ok && flw == fw)) begin
            if (mdl[fw].size() == 0) e_unf = 1; else pop_go = 1;
        end
        if (pop_go) begin
            e_rdv = 1; e_rdata = mdl[fw].pop_front(); e_rwfid = 6'(fw);
        end
        if (wr_go) mdl[ww].push_back(wd);
        if (fl_ok) begin
            mdl[flw].delete(); e_qrst[flw] = 1'b1;
        end
        @(posedge clk); #1;
        wr_valid = 0; feed_valid = 0; flush_valid = 0;
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (q_empty !== {40{1'b1}}) begin errors++; $display("FAIL reset_q_empty got=%h exp=%h", q_empty, {40{1'b1}}); end
        checks++; if (q_vacant !== {40{1'b1}}) begin errors++; $display("FAIL reset_q_vacant got=%h exp=%h", q_vacant, {40{1'b1}}); end
        checks++; if ({q_reset, rd_valid, rd_wfid, rd_data, wr_overflow, rd_underflow} !== '0) begin
            errors++; $display("FAIL reset_outputs q_reset=%h rd_valid=%b rd_wfid=%0d rd_data=%h ovf=%b unf=%b exp all zero",
                              q_reset, rd_valid, rd_wfid, rd_data, wr_overflow, rd_underflow);
        end
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        m_clear();
    endtask

    task automatic test_basic();
        step(1, 5, 32'hA0, 0, 0, 0, 0);
        checks++; if (q_empty[5] !== 1'b0) begin errors++; $display("FAIL basic_empty_after_wr got=%b exp=0", q_empty[5]); end
        step(1, 5, 32'hA1, 0, 0, 0, 0);
        step(0, 0, '0, 1, 5, 0, 0);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hA0 || rd_wfid !== 6'd5) begin
            errors++; $display("FAIL basic_pop1 got v=%b d=%h id=%0d exp v=1 d=a0 id=5", rd_valid, rd_data, rd_wfid); end
        step(0, 0, '0, 1, 5, 0, 0);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hA1 || rd_wfid !== 6'd5) begin
            errors++; $display("FAIL basic_pop2 got v=%b d=%h id=%0d exp v=1 d=a1 id=5", rd_valid, rd_data, rd_wfid); end
        checks++; if (q_empty[5] !== 1'b1) begin errors++; $display("FAIL basic_empty_after_pop got=%b exp=1", q_empty[5]); end
        idle();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_rdvalid_pulse got=%b exp=0", rd_valid); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 4; k++) begin
            step(1, 39, 32'h390 + 32'(k), 0, 0, 0, 0);
            checks++; if (q_vacant[39] !== (k < 2)) begin
                errors++; $display("FAIL ovf_vacant_after_wr%0d got=%b exp=%b", k + 1, q_vacant[39], (k < 2)); end
        end
        step(1, 39, 32'hDEAD, 0, 0, 0, 0);
        checks++; if (wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b exp=1", wr_overflow); end
        idle();
        checks++; if (wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_clear got=%b exp=0", wr_overflow); end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, '0, 1, 39, 0, 0);
            checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h390 + 32'(k)) begin
                errors++; $display("FAIL ovf_drain%0d got v=%b d=%h exp v=1 d=%h", k, rd_valid, rd_data, 32'h390 + 32'(k)); end
        end
    endtask

    task automatic test_underflow();
        step(0, 0, '0, 1, 0, 0, 0);
        checks++; if (rd_underflow !== 1'b1 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL unf_empty_pop got unf=%b v=%b exp unf=1 v=0", rd_underflow, rd_valid); end
        step(1, 1, 32'hB1, 1, 1, 0, 0);
        checks++; if (rd_underflow !== 1'b1 || rd_valid !== 1'b0 || wr_overflow !== 1'b0) begin
            errors++; $display("FAIL unf_wr_pop_same got unf=%b v=%b ovf=%b exp unf=1 v=0 ovf=0", rd_underflow, rd_valid, wr_overflow); end
        checks++; if (q_empty[1] !== 1'b0 || q_vacant[1] !== 1'b1) begin
            errors++; $display("FAIL unf_wf1_holds_one got empty=%b vacant=%b exp empty=0 vacant=1", q_empty[1], q_vacant[1]); end
        step(0, 0, '0, 1, 1, 0, 0);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hB1 || rd_wfid !== 6'd1) begin
            errors++; $display("FAIL unf_wf1_pop got v=%b d=%h id=%0d exp v=1 d=b1 id=1", rd_valid, rd_data, rd_wfid); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) step(1, 7, 32'h70 + 32'(k), 0, 0, 0, 0);
        step(1, 7, 32'h7F, 1, 7, 1, 7);
        checks++; if (q_reset !== (40'd1 << 7)) begin errors++; $display("FAIL flush_qreset got=%h exp=%h", q_reset, 40'd1 << 7); end
        checks++; if (q_empty[7] !== 1'b1 || q_vacant[7] !== 1'b1) begin
            errors++; $display("FAIL flush_state got empty=%b vacant=%b exp 1 1", q_empty[7], q_vacant[7]); end
        checks++; if (rd_valid !== 1'b0 || wr_overflow !== 1'b0 || rd_underflow !== 1'b0) begin
            errors++; $display("FAIL flush_no_pulses got v=%b ovf=%b unf=%b exp 0 0 0", rd_valid, wr_overflow, rd_underflow); end
        idle();
        checks++; if (q_reset !== '0) begin errors++; $display("FAIL flush_qreset_clear got=%h exp=0", q_reset); end
        // Out-of-range ids on every port must be ignored silently.
        step(1, 45, 32'h1, 1, 50, 1, 63);
        checks++; if ({q_reset, rd_valid, wr_overflow, rd_underflow} !== '0 || q_empty !== {40{1'b1}}) begin
            errors++; $display("FAIL oor_ignored got qrst=%h v=%b ovf=%b unf=%b empty=%h exp all idle", q_reset, rd_valid, wr_overflow, rd_underflow, q_empty); end
    endtask

    task automatic test_wrap();
        step(1, 20, 32'd0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            step(k < 10, 20, 32'(k), 1, 20, 0, 0);
            checks++; if (rd_valid !== 1'b1 || rd_data !== 32'(k - 1) || q_vacant[20] !== 1'b1) begin
                errors++; $display("FAIL wrap_%0d got v=%b d=%0d vacant=%b exp v=1 d=%0d vacant=1", k, rd_valid, rd_data, q_vacant[20], k - 1); end
        end
        checks++; if (q_empty[20] !== 1'b1) begin errors++; $display("FAIL wrap_final_empty got=%b exp=1", q_empty[20]); end
    endtask

    task automatic test_random();
        int ids [6] = '{0, 1, 2, 39, 41, 63};
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 60, ids[$urandom_range(0, 5)], $urandom,
                 $urandom_range(0, 99) < 50, ids[$urandom_range(0, 5)],
                 $urandom_range(0, 99) < 6,  ids[$urandom_range(0, 5)]);
            checks++;
            if (rd_valid !== e_rdv || rd_data !== e_rdata || rd_wfid !== e_rwfid || wr_overflow !== e_ovf ||
                rd_underflow !== e_unf || q_reset !== e_qrst || q_empty !== m_empty() || q_vacant !== m_vacant()) begin
                errors++;
                $display("FAIL random_cycle%0d got v=%b d=%h id=%0d ovf=%b unf=%b qrst=%h empty=%h vac=%h exp v=%b d=%h id=%0d ovf=%b unf=%b qrst=%h empty=%h vac=%h",
                         n, rd_valid, rd_data, rd_wfid, wr_overflow, rd_underflow, q_reset, q_empty, q_vacant,
                         e_rdv, e_rdata, e_rwfid, e_ovf, e_unf, e_qrst, m_empty(), m_vacant());
            end
        end
    endtask

    task automatic test_reset_midop();
        step(1, 2, 32'h22, 0, 0, 0, 0);
        step(1, 3, 32'h33, 0, 0, 0, 0);
        step(1, 4, 32'h44, 0, 0, 0, 0);
        step(1, 2, 32'h23, 1, 2, 0, 0);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h22) begin
            errors++; $display("FAIL midrst_pending got v=%b d=%h exp v=1 d=22", rd_valid, rd_data); end
        #2 rst = 0;
        #1;
        checks++; if (q_empty !== {40{1'b1}} || q_vacant !== {40{1'b1}}) begin
            errors++; $display("FAIL midrst_state got empty=%h vacant=%h exp all ones", q_empty, q_vacant); end
        checks++; if ({q_reset, rd_valid, rd_wfid, rd_data, wr_overflow, rd_underflow} !== '0) begin
            errors++; $display("FAIL midrst_outputs got v=%b id=%0d d=%h ovf=%b unf=%b qrst=%h exp all zero",
                              rd_valid, rd_wfid, rd_data, wr_overflow, rd_underflow, q_reset); end
        m_clear();
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        step(0, 0, '0, 1, 3, 0, 0);
        checks++; if (rd_underflow !== 1'b1 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_queue_cleared got unf=%b v=%b exp unf=1 v=0", rd_underflow, rd_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_flush();
        test_wrap();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end
endmodule
